// File: rtl/tl_ctrl_fsm.sv
// Traffic-light style controller for a FIFO bank: INIT/IDLE/ACTIVE/ERROR
// sequencing with threshold registers and a sticky per-FIFO error record.
module tl_ctrl_fsm #(
   parameter int N_FIFOS   = 5,
   parameter int U_MFS     = 4,
   parameter int U_VCS     = 4,
   parameter int U_DS      = 4,
   parameter int IDLE_WAIT = 3,
   parameter int DEF_MF    = 1,
   parameter int DEF_VC    = 1,
   parameter int DEF_D     = 1,
   localparam int IW = (N_FIFOS > 1) ? $clog2(N_FIFOS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init,
   input  logic               err_clr,
   input  logic [U_MFS-1:0]   umbral_MFs,
   input  logic [U_VCS-1:0]   umbral_VCs,
   input  logic [U_DS-1:0]    umbral_Ds,
   input  logic [N_FIFOS-1:0] FIFO_empties,
   input  logic [N_FIFOS-1:0] FIFO_errors,
   output logic [2:0]         present_state,
   output logic [2:0]         next_state,
   output logic               error_out,
   output logic               active_out,
   output logic               idle_out,
   output logic               next_error,
   output logic [U_MFS-1:0]   umbral_MFs_out,
   output logic [U_VCS-1:0]   umbral_VCs_out,
   output logic [U_DS-1:0]    umbral_Ds_out,
   output logic [U_MFS-1:0]   next_umbral_MFs,
   output logic [U_VCS-1:0]   next_umbral_VCs,
   output logic [U_DS-1:0]    next_umbral_Ds,
   output logic [N_FIFOS-1:0] error_mask,
   output logic [IW-1:0]      error_idx
);

   localparam int CW = $clog2(IDLE_WAIT + 1);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [U_MFS-1:0]   mf_q, mf_d;
   logic [U_VCS-1:0]   vc_q, vc_d;
   logic [U_DS-1:0]    ds_q, ds_d;
   logic [N_FIFOS-1:0] mask_q, mask_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic               err_q, err_d;
   logic               act_q, act_d;
   logic               idl_q, idl_d;
   logic [IW-1:0]      low_idx;
   logic               err_any, all_empty;

   assign err_any   = |FIFO_errors;
   assign all_empty = &FIFO_empties;

   // Scan downward so the lowest set bit wins.
   always_comb begin
      low_idx = '0;
      for (int i = N_FIFOS - 1; i >= 0; i--) begin
         if (FIFO_errors[i]) low_idx = IW'(i);
      end
   end

   assign cnt_inc = (cnt_q == CW'(IDLE_WAIT)) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      mf_d    = mf_q;
      vc_d    = vc_q;
      ds_d    = ds_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      case (state_q)
         S_RESET: state_d = S_INIT;
         S_INIT: begin
            if (err_any) begin
               state_d = S_ERROR;
               mask_d  = FIFO_errors;
               idx_d   = low_idx;
            end else if (init) begin
               mf_d = umbral_MFs;
               vc_d = umbral_VCs;
               ds_d = umbral_Ds;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (err_any) begin
               state_d = S_ERROR;
               mask_d  = FIFO_errors;
               idx_d   = low_idx;
            end else if (init) begin
               state_d = S_INIT;
            end else if (!all_empty) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (err_any) begin
               state_d = S_ERROR;
               mask_d  = FIFO_errors;
               idx_d   = low_idx;
            end else if (init) begin
               state_d = S_INIT;
            end else if (all_empty) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(IDLE_WAIT)) state_d = S_IDLE;
            end
         end
         S_ERROR: begin
            mask_d = mask_q | FIFO_errors;
            if (err_clr && !err_any) begin
               state_d = S_INIT;
               mask_d  = '0;
               idx_d   = '0;
            end
         end
         default: state_d = S_RESET;
      endcase
      err_d = (state_d == S_ERROR);
      act_d = (state_d == S_ACTIVE);
      idl_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RESET;
         mf_q    <= U_MFS'(DEF_MF);
         vc_q    <= U_VCS'(DEF_VC);
         ds_q    <= U_DS'(DEF_D);
         mask_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         act_q   <= 1'b0;
         idl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mf_q    <= mf_d;
         vc_q    <= vc_d;
         ds_q    <= ds_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         act_q   <= act_d;
         idl_q   <= idl_d;
      end
   end

   assign present_state   = state_q;
   assign next_state      = state_d;
   assign next_error      = (state_d == S_ERROR);
   assign error_out       = err_q;
   assign active_out      = act_q;
   assign idle_out        = idl_q;
   assign umbral_MFs_out  = mf_q;
   assign umbral_VCs_out  = vc_q;
   assign umbral_Ds_out   = ds_q;
   assign next_umbral_MFs = mf_d;
   assign next_umbral_VCs = vc_d;
   assign next_umbral_Ds  = ds_d;
   assign error_mask      = mask_q;
   assign error_idx       = idx_q;

endmodule

// File: tb/tb_tl_ctrl_fsm.sv
// Scoreboard bench for tl_ctrl_fsm: expected post-edge state pushed with
// each stimulus, next-state outputs checked before the edge, registers after.
module tb_tl_ctrl_fsm;

   localparam logic [2:0] RST = 3'd0;
   localparam logic [2:0] INI = 3'd1;
   localparam logic [2:0] IDL = 3'd2;
   localparam logic [2:0] ACT = 3'd3;
   localparam logic [2:0] ERR = 3'd4;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic       err_clr;
   logic [3:0] umbral_MFs, umbral_VCs, umbral_Ds;
   logic [4:0] FIFO_empties, FIFO_errors;
   logic [2:0] present_state, next_state;
   logic       error_out, active_out, idle_out, next_error;
   logic [3:0] umbral_MFs_out, umbral_VCs_out, umbral_Ds_out;
   logic [3:0] next_umbral_MFs, next_umbral_VCs, next_umbral_Ds;
   logic [4:0] error_mask;
   logic [2:0] error_idx;

   typedef struct {
      logic [2:0] st;
      logic [4:0] mask;
      logic [2:0] idx;
      logic [3:0] mf;
      logic [3:0] vc;
      logic [3:0] d;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   tl_ctrl_fsm dut (
      .clk(clk), .reset(reset), .init(init), .err_clr(err_clr),
      .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs),
      .umbral_Ds(umbral_Ds), .FIFO_empties(FIFO_empties),
      .FIFO_errors(FIFO_errors), .present_state(present_state),
      .next_state(next_state), .error_out(error_out),
      .active_out(active_out), .idle_out(idle_out),
      .next_error(next_error), .umbral_MFs_out(umbral_MFs_out),
      .umbral_VCs_out(umbral_VCs_out), .umbral_Ds_out(umbral_Ds_out),
      .next_umbral_MFs(next_umbral_MFs),
      .next_umbral_VCs(next_umbral_VCs),
      .next_umbral_Ds(next_umbral_Ds), .error_mask(error_mask),
      .error_idx(error_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".st"}, 32'(present_state), 32'(RST));
      chk({tag, ".flags"}, {error_out, active_out, idle_out}, 0);
      chk({tag, ".mask"}, 32'(error_mask), 0);
      chk({tag, ".idx"}, 32'(error_idx), 0);
      chk({tag, ".thr"},
          {umbral_MFs_out, umbral_VCs_out, umbral_Ds_out}, 32'h111);
   endtask

   task automatic step(input string tag,
                       input logic i, input logic c,
                       input logic [3:0] mf, input logic [3:0] vc,
                       input logic [3:0] d,
                       input logic [4:0] emp, input logic [4:0] err,
                       input logic [2:0] est, input logic [4:0] emask,
                       input logic [2:0] eidx, input logic [3:0] emf,
                       input logic [3:0] evc, input logic [3:0] ed);
      exp_t e;
      init         = i;
      err_clr      = c;
      umbral_MFs   = mf;
      umbral_VCs   = vc;
      umbral_Ds    = d;
      FIFO_empties = emp;
      FIFO_errors  = err;
      e.st = est; e.mask = emask; e.idx = eidx;
      e.mf = emf; e.vc = evc; e.d = ed;
      sb_q.push_back(e);
      #1;
      chk({tag, ".nst"}, 32'(next_state), 32'(sb_q[0].st));
      chk({tag, ".nerr"}, 32'(next_error), 32'(sb_q[0].st == ERR));
      chk({tag, ".nthr"},
          {next_umbral_MFs, next_umbral_VCs, next_umbral_Ds},
          {sb_q[0].mf, sb_q[0].vc, sb_q[0].d});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({tag, ".st"}, 32'(present_state), 32'(e.st));
      chk({tag, ".flags"}, {error_out, active_out, idle_out},
          {e.st == ERR, e.st == ACT, e.st == IDL});
      chk({tag, ".mask"}, 32'(error_mask), 32'(e.mask));
      chk({tag, ".idx"}, 32'(error_idx), 32'(e.idx));
      chk({tag, ".thr"},
          {umbral_MFs_out, umbral_VCs_out, umbral_Ds_out},
          {e.mf, e.vc, e.d});
   endtask

   initial begin
      reset = 1'b1; init = 1'b0; err_clr = 1'b0;
      umbral_MFs = '0; umbral_VCs = '0; umbral_Ds = '0;
      FIFO_empties = 5'b11111; FIFO_errors = '0;
      #2;
      chk_reset_vals("rst0");
      #10;
      reset = 1'b0;
      // configuration
      step("cfg1", 1, 0, 7, 5, 3, 5'h1f, 0, INI, 0, 0, 1, 1, 1);
      step("cfg2", 1, 0, 7, 5, 3, 5'h1f, 0, INI, 0, 0, 7, 5, 3);
      step("cfg3", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      // idle wait
      step("act0", 0, 0, 0, 0, 0, 5'b11011, 0, ACT, 0, 0, 7, 5, 3);
      step("act1", 0, 0, 0, 0, 0, 5'h1f, 0, ACT, 0, 0, 7, 5, 3);
      step("act2", 0, 0, 0, 0, 0, 5'h1f, 0, ACT, 0, 0, 7, 5, 3);
      step("act3", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      // counter restart at count 2
      step("rs0", 0, 0, 0, 0, 0, 5'b11110, 0, ACT, 0, 0, 7, 5, 3);
      step("rs1", 0, 0, 0, 0, 0, 5'h1f, 0, ACT, 0, 0, 7, 5, 3);
      step("rs2", 0, 0, 0, 0, 0, 5'h1f, 0, ACT, 0, 0, 7, 5, 3);
      step("rs3", 0, 0, 0, 0, 0, 5'b11110, 0, ACT, 0, 0, 7, 5, 3);
      step("rs4", 0, 0, 0, 0, 0, 5'h1f, 0, ACT, 0, 0, 7, 5, 3);
      step("rs5", 0, 0, 0, 0, 0, 5'h1f, 0, ACT, 0, 0, 7, 5, 3);
      step("rs6", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      // errors from ACTIVE
      step("e0", 0, 0, 0, 0, 0, 5'h00, 0, ACT, 0, 0, 7, 5, 3);
      step("e1", 0, 0, 0, 0, 0, 5'h00, 5'b01100, ERR, 5'b01100, 2, 7, 5, 3);
      step("e2", 0, 0, 0, 0, 0, 5'h00, 5'b10000, ERR, 5'b11100, 2, 7, 5, 3);
      step("e3", 0, 1, 0, 0, 0, 5'h00, 5'b00001, ERR, 5'b11101, 2, 7, 5, 3);
      step("e4", 0, 1, 0, 0, 0, 5'h00, 5'b00000, INI, 0, 0, 7, 5, 3);
      step("e5", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      // init and error together in IDLE
      step("ie0", 1, 0, 9, 9, 9, 5'h1f, 5'b00010, ERR, 5'b00010, 1, 7, 5, 3);
      step("ie1", 0, 1, 0, 0, 0, 5'h1f, 0, INI, 0, 0, 7, 5, 3);
      step("ie2", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      // error history, then init from ACTIVE
      step("h0", 0, 0, 0, 0, 0, 5'h00, 0, ACT, 0, 0, 7, 5, 3);
      step("h1", 0, 0, 0, 0, 0, 5'h00, 5'b00001, ERR, 5'b00001, 0, 7, 5, 3);
      step("h2", 0, 1, 0, 0, 0, 5'h00, 0, INI, 0, 0, 7, 5, 3);
      step("h3", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      step("h4", 0, 0, 0, 0, 0, 5'h00, 0, ACT, 0, 0, 7, 5, 3);
      step("h5", 1, 0, 2, 3, 4, 5'h00, 0, INI, 0, 0, 7, 5, 3);
      step("h6", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 7, 5, 3);
      step("h7", 0, 0, 0, 0, 0, 5'h00, 0, ACT, 0, 0, 7, 5, 3);
      // error state held when reset hits mid-ACTIVE afterwards
      step("h8", 0, 0, 0, 0, 0, 5'h00, 5'b01000, ERR, 5'b01000, 3, 7, 5, 3);
      #3;
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_err");
      #2;
      reset = 1'b0;
      step("pr0", 0, 0, 0, 0, 0, 5'h1f, 0, INI, 0, 0, 1, 1, 1);
      step("pr1", 0, 0, 0, 0, 0, 5'h1f, 0, IDL, 0, 0, 1, 1, 1);
      step("pr2", 0, 0, 0, 0, 0, 5'h00, 0, ACT, 0, 0, 1, 1, 1);
      #3;
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_act");
      #2;
      reset = 1'b0;
      step("pr3", 0, 0, 0, 0, 0, 5'h1f, 0, INI, 0, 0, 1, 1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tl_ctrl_fsm.md
TL_CTRL_FSM -- requirements
Module: tl_ctrl_fsm

Interface
REQ-001 SHALL have parameter N_FIFOS, default 5: number of monitored FIFOs.
REQ-002 SHALL have parameter U_MFS, default 4: main-FIFO threshold width.
REQ-003 SHALL have parameter U_VCS, default 4: VC-FIFO threshold width.
REQ-004 SHALL have parameter U_DS, default 4: D-FIFO threshold width.
REQ-005 SHALL have parameter IDLE_WAIT, default 3, legal range >=1: consecutive all-empty cycles required before ACTIVE->IDLE.
REQ-006 SHALL have parameters DEF_MF, DEF_VC, DEF_D, default 1 each: threshold reset values.
REQ-007 SHALL operate on one clock with an asynchronous, active-high reset; the clock port is named clk and the reset port is named reset.
REQ-008 Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- init  in  1  configuration request
- err_clr  in  1  error acknowledge/clear
- umbral_MFs  in  U_MFS  main threshold input
- umbral_VCs  in  U_VCS  VC threshold input
- umbral_Ds  in  U_DS  D threshold input
- FIFO_empties  in  N_FIFOS  per-FIFO empty flags
- FIFO_errors  in  N_FIFOS  per-FIFO error flags
- present_state  out  3  registered state
- next_state  out  3  combinational next state
- error_out, active_out, idle_out  out  1 each  registered state flags
- next_error  out  1  combinational: next_state==ERROR
- umbral_MFs_out, umbral_VCs_out, umbral_Ds_out  out  U_MFS/U_VCS/U_DS  registered thresholds
- next_umbral_MFs, next_umbral_VCs, next_umbral_Ds  out  same widths  combinational next thresholds
- error_mask  out  N_FIFOS  sticky per-FIFO error record
- error_idx  out  max(1,clog2(N_FIFOS))  lowest erroring FIFO index at ERROR entry

Function
REQ-009 State encoding SHALL be: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5-7 SHALL go to RESET.
REQ-010 Every state transition SHALL take effect on the clk edge after its condition is sampled.
REQ-011 Error detection SHALL use err_any = |FIFO_errors.
REQ-012 Error detection SHALL have highest priority in INIT, IDLE and ACTIVE.
REQ-013 RESET SHALL go to INIT unconditionally.
REQ-014 INIT: err_any -> ERROR; else init=1 -> stay in INIT and load umbral_*s into the threshold registers each cycle; else -> IDLE.
REQ-015 Threshold registers SHALL change only on cycles where present_state==INIT and init=1.
REQ-016 next_umbral_* SHALL equal the value to be registered at the next edge.
REQ-017 IDLE: err_any -> ERROR; else init -> INIT; else any FIFO_empties bit 0 -> ACTIVE; else stay.
REQ-018 ACTIVE: err_any -> ERROR; else init -> INIT; else all-empty for IDLE_WAIT consecutive cycles -> IDLE; else stay.
REQ-019 Idle counter SHALL increment on each all-empty cycle in ACTIVE.
REQ-020 Idle counter SHALL clear on any non-empty cycle and on ACTIVE entry.
REQ-021 Idle counter SHALL saturate and never wrap.
REQ-022 ERROR SHALL be exited only by err_clr=1 with err_any=0, going to INIT.
REQ-023 In ERROR, err_clr with err_any=1 SHALL be ignored.
REQ-024 On entry to ERROR, error_mask SHALL load FIFO_errors and error_idx SHALL load the lowest set bit index.
REQ-025 While in ERROR, error_mask SHALL OR in new FIFO_errors; error_idx SHALL hold.
REQ-026 error_mask and error_idx SHALL clear on the ERROR->INIT transition.
REQ-027 error_out, active_out and idle_out SHALL be 1 exactly when present_state is ERROR, ACTIVE and IDLE respectively.
REQ-028 Thresholds SHALL persist across ERROR and IDLE/ACTIVE.

Reset
REQ-029 While reset=1, asynchronously: present_state=RESET, all flags 0, error_mask=0, error_idx=0, idle counter=0, umbral_*_out=DEF_*.
REQ-030 Reset asserted mid-operation, including in ERROR, SHALL abort immediately and discard sticky error state.
REQ-031 After reset release, the first edge SHALL move the block to INIT.

Verification
REQ-032 Reset then init=1 with MF=7, VC=5, D=3 for 2 cycles, then init=0 -> umbral_*_out=7/5/3; state sequence RESET,INIT,INIT,IDLE; idle_out=1.
REQ-033 In IDLE, FIFO_empties=5'b11011 for 1 cycle then all-ones held -> ACTIVE for 1+3 cycles, then IDLE (IDLE_WAIT=3); counter restarts if non-empty occurs at count 2.
REQ-034 In ACTIVE, FIFO_errors=5'b01100 for 1 cycle, then 5'b10000 -> ERROR; error_idx=2; error_mask=5'b11100; error_out=1.
REQ-035 In ERROR: err_clr=1 with FIFO_errors=5'b00001 -> stays ERROR; then err_clr=1 with FIFO_errors=0 -> INIT with error_mask=0; thresholds unchanged.
REQ-036 Simultaneous init=1 and FIFO_errors=5'b00010 in IDLE -> ERROR with error_idx=1, thresholds not loaded.
REQ-037 reset pulse mid-ACTIVE with ERROR-state history -> all outputs at reset values before the next clk edge; umbral_*_out=1/1/1.
